// File: rtl/oam_dma_ctrl.sv
// Sprite DMA controller: a CPU write to DMA_REG_ADDR copies one 256-byte page
// into the sprite-RAM data register, stalling the CPU for the whole transfer.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_write_en,
  input  logic        cpu_read_en,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data_out,
  output logic        bus_write_en,
  output logic        bus_read_en,
  input  logic [7:0]  bus_data_in,
  output logic        cpu_stall,
  output logic        dma_busy,
  output logic        dma_done,
  output logic [7:0]  dma_index
);

  typedef enum logic [2:0] {IDLE, DUMMY, ALIGN, READ, LATCH, WRITE} state_t;

  state_t     state;
  state_t     state_next;
  logic       parity;
  logic [7:0] page;
  logic [7:0] byte_reg;
  logic       trigger;

  assign trigger = cpu_write_en && (cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      parity    <= 1'b0;
      page      <= 8'h00;
      byte_reg  <= 8'h00;
      dma_index <= 8'h00;
      dma_done  <= 1'b0;
    end else begin
      state    <= state_next;
      parity   <= ~parity;
      dma_done <= (state == WRITE) && (dma_index == 8'hFF);
      case (state)
        IDLE: begin
          if (trigger) begin
            page      <= cpu_data_in;
            dma_index <= 8'h00;
          end
        end
        LATCH:   byte_reg  <= bus_data_in;
        WRITE:   dma_index <= dma_index + 8'd1;
        default: ;
      endcase
    end
  end

  // Outside IDLE the CPU side is fully disconnected; only the DMA drives the bus.
  always_comb begin
    state_next   = state;
    bus_addr     = 16'h0000;
    bus_data_out = 8'h00;
    bus_write_en = 1'b0;
    bus_read_en  = 1'b0;
    cpu_stall    = 1'b1;
    dma_busy     = 1'b1;
    case (state)
      IDLE: begin
        bus_addr     = cpu_addr;
        bus_data_out = cpu_data_in;
        bus_write_en = cpu_write_en;
        bus_read_en  = cpu_read_en;
        cpu_stall    = 1'b0;
        dma_busy     = 1'b0;
        if (trigger) state_next = DUMMY;
      end
      DUMMY: state_next = parity ? ALIGN : READ;
      ALIGN: state_next = READ;
      READ: begin
        bus_addr    = {page, dma_index};
        bus_read_en = 1'b1;
        state_next  = LATCH;
      end
      LATCH: begin
        bus_addr   = {page, dma_index};
        state_next = WRITE;
      end
      WRITE: begin
        bus_addr     = OAM_DATA_ADDR;
        bus_data_out = byte_reg;
        bus_write_en = 1'b1;
        state_next   = (dma_index == 8'hFF) ? IDLE : READ;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: stimulus queues the expected bus
// transactions of each page copy, a negedge monitor consumes and checks them.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_write_en;
  logic        cpu_read_en;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_out;
  logic        bus_write_en;
  logic        bus_read_en;
  logic [7:0]  bus_data_in;
  logic        cpu_stall;
  logic        dma_busy;
  logic        dma_done;
  logic [7:0]  dma_index;

  oam_dma_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_write_en(cpu_write_en), .cpu_read_en(cpu_read_en),
    .bus_addr(bus_addr), .bus_data_out(bus_data_out),
    .bus_write_en(bus_write_en), .bus_read_en(bus_read_en),
    .bus_data_in(bus_data_in),
    .cpu_stall(cpu_stall), .dma_busy(dma_busy), .dma_done(dma_done),
    .dma_index(dma_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        is_write;
    logic [7:0]  data;
    logic [7:0]  idx;
  } ev_t;

  ev_t exp_q[$];
  int  done_q[$];
  int  tests = 0;
  int  fails = 0;
  int  stall_cnt = 0;
  int  cyc = 0;
  logic [7:0] seed = 8'h00;
  logic       invert_mode = 1'b0;
  ev_t        mon_e;

  // Memory behind the decoder, a pure function of the address
  always_comb begin
    if (invert_mode) bus_data_in = ~bus_addr[7:0];
    else             bus_data_in = 8'((bus_addr[7:0] * 8'd37) + (bus_addr[15:8] ^ seed));
  end

  function automatic logic [7:0] memModel(logic [15:0] a);
    if (invert_mode) return ~a[7:0];
    return 8'((a[7:0] * 8'd37) + (a[15:8] ^ seed));
  endfunction

  // Edges since reset release; the free-running parity bit equals cyc % 2
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  // Monitor: checks passthrough in IDLE and pops expected DMA traffic
  always @(negedge clk) begin
    if (rst) begin
      stall_cnt = 0;
    end else begin
      if (cpu_stall) stall_cnt++;
      checkOutput("busy_eq_stall", {63'd0, dma_busy}, {63'd0, cpu_stall});
      if (!dma_busy) begin
        checkOutput("passthrough",
                    {38'd0, bus_addr, bus_data_out, bus_write_en, bus_read_en},
                    {38'd0, cpu_addr, cpu_data_in, cpu_write_en, cpu_read_en});
      end else if (bus_read_en || bus_write_en) begin
        if (exp_q.size() == 0) begin
          failNow("unexpected_dma_access");
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("strobes", {62'd0, bus_write_en, bus_read_en},
                      mon_e.is_write ? 64'd2 : 64'd1);
          checkOutput("dma_addr", {48'd0, bus_addr}, {48'd0, mon_e.addr});
          if (mon_e.is_write) checkOutput("dma_data", {56'd0, bus_data_out}, {56'd0, mon_e.data});
          else                checkOutput("dma_index", {56'd0, dma_index}, {56'd0, mon_e.idx});
        end
      end
      if (dma_done) begin
        if (done_q.size() == 0) begin
          failNow("unexpected_done");
        end else begin
          checkOutput("stall_cycles", 64'(stall_cnt), 64'(done_q.pop_front()));
          checkOutput("pending_after_done", 64'(exp_q.size()), 64'd0);
          checkOutput("index_wrap", {56'd0, dma_index}, 64'd0);
        end
        stall_cnt = 0;
      end
    end
  end

  task automatic driveIdle(bit allow_trigger_addr);
    cpu_addr     = 16'($urandom);
    if (!allow_trigger_addr && cpu_addr == 16'h4014) cpu_addr = 16'h4015;
    cpu_data_in  = 8'($urandom);
    cpu_write_en = 1'($urandom);
    cpu_read_en  = ~cpu_write_en & 1'($urandom);
  endtask

  task automatic applyStimulus(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      driveIdle(1'b0);
    end
  endtask

  task automatic quietBus();
    cpu_addr = 16'h0000; cpu_data_in = 8'h00; cpu_write_en = 1'b0; cpu_read_en = 1'b0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    quietBus();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {60'd0, cpu_stall, dma_busy, dma_done, 1'b0},  64'd0);
    checkOutput("reset_index", {56'd0, dma_index}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // align: 0/1 forces the parity seen in DUMMY, 2 leaves it random
  task automatic runTransfer(logic [7:0] page, int align, bit inv, logic [7:0] sd,
                             bit poke100, bit reset_at10);
    int a;
    bit poked = 0;
    bit finished = 0;
    ev_t e;
    @(posedge clk); #1;
    driveIdle(1'b0);
    if (align != 2) begin
      while (((cyc + 1) % 2) != align) begin
        @(posedge clk); #1;
        driveIdle(1'b0);
      end
    end
    a = (cyc + 1) % 2;
    seed = sd;
    invert_mode = inv;
    for (int i = 0; i < 256; i++) begin
      e.addr = {page, 8'(i)}; e.is_write = 1'b0; e.data = 8'h00; e.idx = 8'(i);
      exp_q.push_back(e);
      e.addr = 16'h2004; e.is_write = 1'b1; e.data = memModel({page, 8'(i)});
      exp_q.push_back(e);
    end
    done_q.push_back(1 + a + 768);
    cpu_addr = 16'h4014; cpu_data_in = page; cpu_write_en = 1'b1; cpu_read_en = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (!dma_busy) begin
        quietBus();
        finished = 1;
        break;
      end
      if (reset_at10 && !bus_read_en && !bus_write_en && dma_index == 8'd10 &&
          bus_addr == {page, 8'd10}) begin
        rst = 1'b1;
        exp_q.delete();
        done_q.delete();
        driveIdle(1'b0);
        #1;
        checkOutput("rst_mid_outputs", {61'd0, cpu_stall, dma_busy, dma_done}, 64'd0);
        checkOutput("rst_mid_index", {56'd0, dma_index}, 64'd0);
        checkOutput("rst_mid_passthru",
                    {38'd0, bus_addr, bus_data_out, bus_write_en, bus_read_en},
                    {38'd0, cpu_addr, cpu_data_in, cpu_write_en, cpu_read_en});
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(posedge clk); #1;
          checkOutput("no_resume", {63'd0, dma_busy}, 64'd0);
          driveIdle(1'b0);
        end
        return;
      end
      if (poke100 && !poked && bus_read_en && dma_index == 8'd100) begin
        cpu_addr = 16'h4014; cpu_data_in = 8'h05; cpu_write_en = 1'b1; cpu_read_en = 1'b0;
        poked = 1;
      end else begin
        driveIdle(1'b1);
      end
    end
    if (!finished) begin
      failNow("transfer_timeout");
      quietBus();
    end
  endtask

  initial begin
    quietBus();
    applyReset();
    applyStimulus(4);
    @(posedge clk); #1;
    cpu_addr = 16'h2002; cpu_data_in = 8'h00; cpu_read_en = 1'b1; cpu_write_en = 1'b0;
    #1 checkOutput("idle_read_stall", {63'd0, cpu_stall}, 64'd0);
    @(posedge clk); #1;
    cpu_addr = 16'h2000; cpu_data_in = 8'hA5; cpu_read_en = 1'b0; cpu_write_en = 1'b1;
    #1 checkOutput("idle_write_stall", {63'd0, cpu_stall}, 64'd0);
    applyStimulus(3);

    runTransfer(8'h02, 0, 1'b0, 8'h5C, 1'b0, 1'b0);
    applyStimulus(3);
    runTransfer(8'h02, 1, 1'b0, 8'h5C, 1'b0, 1'b0);
    applyStimulus(2);
    runTransfer(8'hFF, 2, 1'b1, 8'h00, 1'b0, 1'b0);
    applyStimulus(2);
    runTransfer(8'h03, 2, 1'b0, 8'h11, 1'b1, 1'b0);
    applyStimulus(2);
    runTransfer(8'h07, 2, 1'b0, 8'h3A, 1'b0, 1'b1);
    for (int t = 0; t < 3; t++) begin
      applyStimulus(int'($urandom_range(1, 6)));
      runTransfer(8'($urandom), 2, 1'($urandom), 8'($urandom), 1'b0, 1'b0);
    end
    applyStimulus(5);
    @(posedge clk); #1;
    quietBus();
    checkOutput("final_queues_empty", 64'(exp_q.size() + done_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 Parameter DMA_REG_ADDR, default 16'h4014, CPU address that triggers DMA.
REQ-002 Parameter OAM_DATA_ADDR, default 16'h2004, sprite-RAM data register address targeted by DMA writes.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cpu_addr  in  16  CPU bus address.
REQ-006 cpu_data_in  in  8  CPU write data.
REQ-007 cpu_write_en  in  1  CPU write strobe.
REQ-008 cpu_read_en  in  1  CPU read strobe.
REQ-009 bus_addr  out  16  address to memory decoder.
REQ-010 bus_data_out  out  8  write data to memory decoder.
REQ-011 bus_write_en  out  1  write strobe to memory decoder.
REQ-012 bus_read_en  out  1  read strobe to memory decoder.
REQ-013 bus_data_in  in  8  read data from memory decoder.
REQ-014 cpu_stall  out  1  high while DMA owns the bus; CPU holds state.
REQ-015 dma_busy  out  1  high in any non-IDLE state.
REQ-016 dma_done  out  1  one-cycle pulse after the final byte is written.
REQ-017 dma_index  out  8  current byte offset within the source page.

Function
REQ-018 States SHALL be IDLE, DUMMY, ALIGN, READ, LATCH, WRITE.
REQ-019 In IDLE, bus_addr/bus_data_out/bus_write_en/bus_read_en SHALL pass through cpu_addr/cpu_data_in/cpu_write_en/cpu_read_en combinationally, including the triggering write.
REQ-020 In IDLE, cpu_write_en high with cpu_addr==DMA_REG_ADDR at a clock edge SHALL latch cpu_data_in into page register P, clear dma_index to 0, and move to DUMMY.
REQ-021 A free-running parity bit SHALL toggle every cycle from 0 at reset.
REQ-022 DUMMY lasts one cycle; next state is ALIGN if parity==1 during DUMMY, else READ.
REQ-023 ALIGN lasts one cycle, then READ.
REQ-024 READ: bus_addr={P,dma_index}, bus_read_en=1, bus_write_en=0; next state LATCH.
REQ-025 LATCH: bus_addr={P,dma_index} held, bus_read_en=0; at edge, bus_data_in captured into byte register B; next state WRITE.
REQ-026 WRITE: bus_addr=OAM_DATA_ADDR, bus_data_out=B, bus_write_en=1, bus_read_en=0; at edge dma_index increments (8-bit wrap).
REQ-027 From WRITE, next state SHALL be READ if dma_index!=8'hFF before increment, else IDLE.
REQ-028 dma_done SHALL be high exactly in the first IDLE cycle after the final WRITE.
REQ-029 In all non-IDLE states, cpu_* inputs SHALL be ignored and never forwarded; bus strobes are 0 in DUMMY and ALIGN.
REQ-030 cpu_stall and dma_busy SHALL be high in DUMMY, ALIGN, READ, LATCH, WRITE and low in IDLE.
REQ-031 Stalled cycles per transfer SHALL total 1+A+768, A=1 if ALIGN inserted else 0.
REQ-032 A write to DMA_REG_ADDR during a transfer SHALL have no effect (no restart, P unchanged).
REQ-033 Writes to OAM_DATA_ADDR SHALL start at whatever sprite address the decoder holds; this block does not write OAM_ADDR.
REQ-034 Page 8'hFF SHALL be legal; source addresses wrap within the page only, never into the next page.

Reset
REQ-035 rst high SHALL immediately force state IDLE, parity 0, P 0, B 0, dma_index 0, dma_done 0, cpu_stall 0, dma_busy 0, regardless of state.
REQ-036 After reset mid-transfer, the block SHALL remain IDLE until a new trigger write; no partial resume.

Verification
REQ-037 Write 8'h02 to 16'h4014 with parity 0 at DUMMY -> READ addresses 16'h0200..16'h02FF in order, 256 writes to 16'h2004 with matching data, cpu_stall high 769 cycles, one dma_done pulse.
REQ-038 Same trigger arranged so parity=1 at DUMMY -> one ALIGN cycle inserted, cpu_stall high 770 cycles, data identical.
REQ-039 Page 8'hFF with memory pattern data=~addr[7:0] -> last read 16'hFFFF, B=8'h00 on final write, dma_index wraps to 0, no 16'h0000 access.
REQ-040 Second write to 16'h4014 (data 8'h05) at byte 100 of an 8'h03 transfer -> transfer continues from 16'h0364 to 16'h03FF unchanged, no restart.
REQ-041 rst pulsed during LATCH of byte 10 -> next cycle cpu_stall=0, dma_busy=0, bus follows cpu_* inputs, no further 16'h2004 writes.
REQ-042 In IDLE, CPU read of 16'h2002 and write to 16'h2000 -> bus outputs equal cpu inputs in the same cycle, cpu_stall stays 0.
